// File: rtl/ram_bist_ctrl.sv
// RAM BIST: write P(k)=k+1 to every address, read back one-cycle-latency data, count mismatches; registered outputs, no backpressure.
// Done pulses at T+2^ADDR_W*2+1 after start; macro RAM_BIST_INV_PASS_EN appends a second WRITE/READ pass using ~P(k).
module ram_bist_ctrl #(
   parameter int ADDR_W = 6,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   output logic              o_ram_ce,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [ADDR_W:0]   o_err_cnt,
   output logic [ADDR_W-1:0] o_fail_addr
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;

   localparam logic [ADDR_W:0] ERR_MAX = {1'b1, {ADDR_W{1'b0}}};

   state_t              state, state_nxt;
   logic                ce_nxt, we_nxt, busy_nxt, done_nxt, pass_nxt;
   logic [ADDR_W-1:0]   addr_nxt, fail_nxt;
   logic [DATA_W-1:0]   wdata_nxt;
   logic [ADDR_W:0]     err_nxt;
   logic                cmp_vld, cmp_vld_nxt;
   logic [ADDR_W-1:0]   cmp_addr, cmp_addr_nxt;
   logic [DATA_W-1:0]   cmp_exp, cmp_exp_nxt;
   logic                abort_act, mismatch;
`ifdef RAM_BIST_INV_PASS_EN
   logic                inv, inv_nxt;
`endif

   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] k);
      logic [ADDR_W:0] s;
      s = {1'b0, k} + (ADDR_W+1)'(1);
      return DATA_W'(s);
   endfunction

   always_comb begin
      state_nxt    = state;
      addr_nxt     = o_ram_addr;
      ce_nxt       = 1'b0;
      we_nxt       = 1'b0;
      wdata_nxt    = '0;
      busy_nxt     = 1'b0;
      done_nxt     = 1'b0;
      pass_nxt     = o_pass;
      err_nxt      = o_err_cnt;
      fail_nxt     = o_fail_addr;
      cmp_vld_nxt  = 1'b0;
      cmp_addr_nxt = o_ram_addr;
`ifdef RAM_BIST_INV_PASS_EN
      inv_nxt      = inv;
      cmp_exp_nxt  = pat(o_ram_addr) ^ {DATA_W{inv}};
`else
      cmp_exp_nxt  = pat(o_ram_addr);
`endif

      abort_act = i_abort && (state == WRITE || state == READ || state == FLUSH);
      mismatch  = cmp_vld && !abort_act && (i_ram_rdata != cmp_exp);
      if (mismatch) begin
         if (o_err_cnt != ERR_MAX) err_nxt = o_err_cnt + (ADDR_W+1)'(1);
         if (o_err_cnt == '0)      fail_nxt = cmp_addr;
      end

      case (state)
         IDLE: begin
            if (i_start) begin
               state_nxt = WRITE;
               ce_nxt    = 1'b1;
               we_nxt    = 1'b1;
               addr_nxt  = '0;
               wdata_nxt = pat('0);
               busy_nxt  = 1'b1;
               err_nxt   = '0;
               fail_nxt  = '0;
               pass_nxt  = 1'b0;
`ifdef RAM_BIST_INV_PASS_EN
               inv_nxt   = 1'b0;
`endif
            end
         end
         WRITE: begin
            busy_nxt = 1'b1;
            ce_nxt   = 1'b1;
            if (o_ram_addr == '1) begin
               state_nxt = READ;
               addr_nxt  = '0;
            end else begin
               addr_nxt  = o_ram_addr + ADDR_W'(1);
               we_nxt    = 1'b1;
`ifdef RAM_BIST_INV_PASS_EN
               wdata_nxt = pat(addr_nxt) ^ {DATA_W{inv}};
`else
               wdata_nxt = pat(addr_nxt);
`endif
            end
         end
         READ: begin
            busy_nxt    = 1'b1;
            cmp_vld_nxt = 1'b1;
            if (o_ram_addr == '1) begin
               addr_nxt  = '0;
               state_nxt = FLUSH;
`ifdef RAM_BIST_INV_PASS_EN
               // first pass done: rewrite the array with the inverted pattern
               if (!inv) begin
                  state_nxt = WRITE;
                  inv_nxt   = 1'b1;
                  ce_nxt    = 1'b1;
                  we_nxt    = 1'b1;
                  wdata_nxt = ~pat('0);
               end
`endif
            end else begin
               addr_nxt = o_ram_addr + ADDR_W'(1);
               ce_nxt   = 1'b1;
            end
         end
         FLUSH: begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == '0);
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (abort_act) begin
         state_nxt   = IDLE;
         ce_nxt      = 1'b0;
         we_nxt      = 1'b0;
         addr_nxt    = '0;
         wdata_nxt   = '0;
         busy_nxt    = 1'b0;
         done_nxt    = 1'b0;
         pass_nxt    = 1'b0;
         cmp_vld_nxt = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         o_ram_ce    <= 1'b0;
         o_ram_we    <= 1'b0;
         o_ram_addr  <= '0;
         o_ram_wdata <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_pass      <= 1'b0;
         o_err_cnt   <= '0;
         o_fail_addr <= '0;
         cmp_vld     <= 1'b0;
         cmp_addr    <= '0;
         cmp_exp     <= '0;
`ifdef RAM_BIST_INV_PASS_EN
         inv         <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         o_ram_ce    <= ce_nxt;
         o_ram_we    <= we_nxt;
         o_ram_addr  <= addr_nxt;
         o_ram_wdata <= wdata_nxt;
         o_busy      <= busy_nxt;
         o_done      <= done_nxt;
         o_pass      <= pass_nxt;
         o_err_cnt   <= err_nxt;
         o_fail_addr <= fail_nxt;
         cmp_vld     <= cmp_vld_nxt;
         cmp_addr    <= cmp_addr_nxt;
         cmp_exp     <= cmp_exp_nxt;
`ifdef RAM_BIST_INV_PASS_EN
         inv         <= inv_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: synchronous RAM model with per-address fault masks, table of test runs, hand-written corner sequences.
module tb_ram_bist_ctrl;

`ifdef RAM_BIST_INV_PASS_EN
   localparam int NPASS = 2;
`else
   localparam int NPASS = 1;
`endif
   localparam int DONE_CYC = 128 * NPASS + 1;

   logic       i_clk = 1'b0;
   logic       i_rst_n, i_start, i_abort;
   logic       o_ram_ce, o_ram_we, o_busy, o_done, o_pass;
   logic [5:0] o_ram_addr, o_fail_addr;
   logic [7:0] o_ram_wdata, i_ram_rdata;
   logic [6:0] o_err_cnt;

   int checks = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   ram_bist_ctrl #(.ADDR_W(6), .DATA_W(8)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
      .o_ram_ce(o_ram_ce), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
      .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata), .o_busy(o_busy),
      .o_done(o_done), .o_pass(o_pass), .o_err_cnt(o_err_cnt), .o_fail_addr(o_fail_addr)
   );

   // RAM model: read data valid the cycle after the address, faults applied on the read path
   logic [7:0] mem [64];
   logic [7:0] or_mk [64];
   logic [7:0] xr_mk [64];
   logic [7:0] all_mk;

   always @(posedge i_clk) begin
      if (o_ram_ce) begin
         if (o_ram_we) mem[o_ram_addr] <= o_ram_wdata;
         else i_ram_rdata <= ((mem[o_ram_addr] | or_mk[o_ram_addr]) ^ xr_mk[o_ram_addr]) ^ all_mk;
      end
   end

   typedef struct {
      int abort_at;
      int or_a;  int or_m;
      int x1_a;  int x1_m;
      int x2_a;  int x2_m;
      int all_m;
      int exp_done;
      int exp_err;
      int exp_fail;
      int exp_pass;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic run_one(input vec_t v, input int id);
      int done_at;
      int ndone;
      for (int a = 0; a < 64; a++) begin
         or_mk[a] = 8'h00;
         xr_mk[a] = 8'h00;
      end
      or_mk[v.or_a] = 8'(v.or_m);
      xr_mk[v.x1_a] = xr_mk[v.x1_a] | 8'(v.x1_m);
      xr_mk[v.x2_a] = xr_mk[v.x2_a] | 8'(v.x2_m);
      all_mk = 8'(v.all_m);
      done_at = -1;
      ndone = 0;
      @(negedge i_clk);
      i_start = 1'b1;
      @(posedge i_clk);
      for (int c = 0; c < DONE_CYC + 4; c++) begin
         @(negedge i_clk);
         if (c == 0) begin
            i_start = 1'b0;
            chk($sformatf("v%0d c0 ce/we/busy", id), {o_ram_ce, o_ram_we, o_busy}, 3'b111);
            chk($sformatf("v%0d c0 addr", id), o_ram_addr, 0);
            chk($sformatf("v%0d c0 wdata", id), o_ram_wdata, 8'h01);
         end
         if (id == 0 && c == 63) chk("c63 we/addr/wdata", {o_ram_we, o_ram_addr, o_ram_wdata}, {1'b1, 6'd63, 8'h40});
         if (id == 0 && c == 64) chk("c64 ce/we/addr", {o_ram_ce, o_ram_we, o_ram_addr}, {1'b1, 1'b0, 6'd0});
`ifdef RAM_BIST_INV_PASS_EN
         if (id == 0 && c == 128) chk("c128 write2 addr0", {o_ram_we, o_ram_addr, o_ram_wdata}, {1'b1, 6'd0, 8'hFE});
         if (id == 0 && c == 192) chk("c192 read2 ce/we", {o_ram_ce, o_ram_we}, 2'b10);
`endif
         if (id == 0 && c == DONE_CYC - 1) chk("flush ce/busy", {o_ram_ce, o_busy}, 2'b01);
         if (id == 0 && c == DONE_CYC) chk("done busy", o_busy, 0);
         if (o_done) begin
            ndone++;
            if (done_at < 0) done_at = c;
         end
         if (v.abort_at > 0 && c == v.abort_at - 1) i_abort = 1'b1;
         if (v.abort_at > 0 && c == v.abort_at) begin
            i_abort = 1'b0;
            chk($sformatf("v%0d abort ce/busy/pass", id), {o_ram_ce, o_busy, o_pass}, 3'b000);
         end
      end
      chk($sformatf("v%0d done cycle", id), done_at, v.exp_done);
      chk($sformatf("v%0d done count", id), ndone, (v.exp_done >= 0) ? 1 : 0);
      chk($sformatf("v%0d err_cnt", id), o_err_cnt, v.exp_err);
      chk($sformatf("v%0d fail_addr", id), o_fail_addr, v.exp_fail);
      chk($sformatf("v%0d pass", id), o_pass, v.exp_pass);
      chk($sformatf("v%0d idle ce/busy", id), {o_ram_ce, o_busy}, 2'b00);
   endtask

   initial begin
      int done_at;
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_abort = 1'b0;
      all_mk  = 8'h00;
      i_ram_rdata = 8'h00;
      for (int a = 0; a < 64; a++) begin
         mem[a] = 8'h00; or_mk[a] = 8'h00; xr_mk[a] = 8'h00;
      end

      //        abort     or_a m  x1_a m     x2_a m  all    done      err        fail pass
      vecs[0] = '{0,        0, 0, 0,  0,     0,  0,  0,     DONE_CYC, 0,         0,   1};
      vecs[1] = '{70,       0, 0, 0,  0,     0,  0,  0,     -1,       0,         0,   0};
      vecs[2] = '{0,        0, 0, 0,  0,     0,  0,  0,     DONE_CYC, 0,         0,   1};
      vecs[3] = '{0,        5, 1, 0,  0,     0,  0,  0,     DONE_CYC, 1,         5,   0};
      vecs[4] = '{0,        0, 0, 10, 1,     20, 1,  0,     DONE_CYC, 2 * NPASS, 10,  0};
      vecs[5] = '{100,      0, 0, 3,  'hFF,  0,  0,  0,     -1,       1,         3,   0};
      vecs[6] = '{DONE_CYC, 0, 0, 0,  0,     0,  0,  0,     -1,       0,         0,   0};
      vecs[7] = '{0,        0, 0, 0,  0,     0,  0,  'h80,  DONE_CYC, 64,        0,   0};
      vecs[8] = '{0,        0, 0, 0,  0,     0,  0,  0,     DONE_CYC, 0,         0,   1};

      repeat (3) @(negedge i_clk);
      chk("reset outputs", {o_ram_ce, o_ram_we, o_ram_addr, o_ram_wdata, o_busy, o_done, o_pass, o_err_cnt, o_fail_addr}, 0);
      i_rst_n = 1'b1;
      repeat (2) @(negedge i_clk);
      chk("idle after reset", {o_ram_ce, o_busy, o_done}, 0);

      for (int i = 0; i < 9; i++) run_one(vecs[i], i);

      // start held through the whole test and into the DONE cycle: no re-trigger, single done pulse
      done_at = -1;
      @(negedge i_clk);
      i_start = 1'b1;
      @(posedge i_clk);
      for (int c = 0; c < DONE_CYC + 4; c++) begin
         @(negedge i_clk);
         if (c == DONE_CYC) i_start = 1'b0;
         if (o_done && done_at < 0) done_at = c;
         if (c == DONE_CYC + 1) chk("start in DONE ignored busy", {o_busy, o_ram_ce}, 2'b00);
         if (c == DONE_CYC + 3) chk("no restart after DONE", o_busy, 0);
      end
      chk("held start done cycle", done_at, DONE_CYC);
      chk("held start pass", o_pass, 1);

      // reset mid-test: outputs clear without waiting for a clock edge
      @(negedge i_clk);
      i_start = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (30) @(posedge i_clk);
      #2 i_rst_n = 1'b0;
      #1 chk("async reset outputs", {o_ram_ce, o_ram_we, o_ram_addr, o_ram_wdata, o_busy, o_done, o_pass, o_err_cnt, o_fail_addr}, 0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      run_one(vecs[0], 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
